// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port integer register file with a load-use scoreboard.
//   - W0: ALU/EX writeback. W1: late load/memory writeback, which also retires
//     the pending-load (busy) bit of its destination.
//   - NUM_RD combinational read ports. Register 0 reads as zero and is never busy.
//   - BYPASS=1 forwards same-cycle write data to the read ports (W1 before W0).
//   - Busy bits are set by iss_en and cleared by W1 writes or by sb_flush.
//
// Ports
//   clk, rst            clock (posedge), asynchronous active-high reset
//   rd_addr / rd_data   packed read ports; port k = [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_busy             per-port "source is a pending load" flag
//   w0_en/addr/data     write port 0
//   w1_en/addr/data     write port 1 (wins on collision with W0, clears busy)
//   iss_en, iss_addr    mark a load destination busy
//   any_busy            OR of all busy bits
//   sb_flush            clear all busy bits (register contents kept)
//
// Optional build macro REGFILE_DBG_PORT_EN adds dbg_addr/dbg_data (a bypass-free
// combinational read port for the register viewer) and dbg_busy (raw busy vector).
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int XLEN   = 32'sd32,
    parameter int NREGS  = 32'sd32,
    parameter int NUM_RD = 32'sd2,
    parameter int BYPASS = 32'sd1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   w0_en,
    input  logic [AW-1:0]          w0_addr,
    input  logic [XLEN-1:0]        w0_data,
    input  logic                   w1_en,
    input  logic [AW-1:0]          w1_addr,
    input  logic [XLEN-1:0]        w1_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic                   any_busy,
    input  logic                   sb_flush
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [AW-1:0]          dbg_addr,
    output logic [XLEN-1:0]        dbg_data,
    output logic [NREGS-1:0]       dbg_busy
`endif
);

    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW-1:0]    ra_s;

    // Register storage: W1 has priority over W0 (younger load result); x0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            regs_r[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (w1_en && (w1_addr == AW'(i))) begin
                    regs_r[i] <= w1_data;
                end else if (w0_en && (w0_addr == AW'(i))) begin
                    regs_r[i] <= w0_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Scoreboard next state: flush first, then issue-set beats W1-clear on one address.
    always_comb begin
        if (sb_flush) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s = busy_r;
        end
        for (int i = 1; i < NREGS; i++) begin
            if (iss_en && (iss_addr == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (w1_en && (w1_addr == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_nxt_s[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports: x0 forced to zero/not busy; a retiring W1 load is forwarded and not a stall.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra_s    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_s = rd_addr[k*AW +: AW];
            if (ra_s == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end else if (BYP_EN && w1_en && (w1_addr == ra_s)) begin
                rd_data[k*XLEN +: XLEN] = w1_data;
                rd_busy[k]              = 1'b0;
            end else if (BYP_EN && w0_en && (w0_addr == ra_s)) begin
                rd_data[k*XLEN +: XLEN] = w0_data;
                rd_busy[k]              = busy_r[ra_s];
            end else begin
                rd_data[k*XLEN +: XLEN] = regs_r[ra_s];
                rd_busy[k]              = busy_r[ra_s];
            end
        end
    end

    assign any_busy = |busy_r;

`ifdef REGFILE_DBG_PORT_EN
    assign dbg_data = regs_r[dbg_addr];
    assign dbg_busy = busy_r;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Table-driven bench for regfile_mp_sb. Two instances share all inputs:
//   one with BYPASS=1 (fully checked) and one with BYPASS=0 (read port 0 data
//   and rd_busy checked). Each vector is applied after a falling edge, outputs
//   are compared one step later, and the following rising edge commits it.
//   Hand-written sequences cover power-on reset and mid-run asynchronous reset.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int AW = 5;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] nb_rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  nb_rd_busy;
    logic        w0_en, w1_en, iss_en, sb_flush;
    logic [4:0]  w0_addr, w1_addr, iss_addr;
    logic [31:0] w0_data, w1_data;
    logic        any_busy, nb_any_busy;

    int total;
    int bad;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy), .sb_flush(sb_flush)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(nb_any_busy), .sb_flush(sb_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] d0, d1;   // expected BYPASS=1 read data
        logic [1:0]  b;        // expected BYPASS=1 rd_busy
        logic        any;      // expected any_busy
        logic [31:0] nd0;      // expected BYPASS=0 read data, port 0
        logic [1:0]  nb;       // expected BYPASS=0 rd_busy
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input logic ie, input logic [4:0] ia, input logic fl,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b,
                                input logic any, input logic [31:0] nd0, input logic [1:0] nb);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl;
        v.d0 = d0; v.d1 = d1; v.b = b; v.any = any; v.nd0 = nd0; v.nb = nb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        w0_en = 1'b0; w0_addr = 5'd0; w0_data = 32'h0;
        w1_en = 1'b0; w1_addr = 5'd0; w1_data = 32'h0;
        iss_en = 1'b0; iss_addr = 5'd0; sb_flush = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        rd_addr = {5'd3, 5'd5};

        //          ra0    ra1    w0e  w0a    w0d            w1e  w1a    w1d            ie   ia     fl    d0             d1             b      any   nd0            nb
        vt[0]  = mk(5'd3,  5'd0,  1'b1,5'd3,  32'hA5A5A5A5, 1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'hA5A5A5A5, 32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        vt[1]  = mk(5'd3,  5'd3,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'hA5A5A5A5, 2'b00);
        vt[2]  = mk(5'd7,  5'd3,  1'b1,5'd7,  32'h11,       1'b1,5'd7,  32'h22,       1'b0,5'd0,  1'b0, 32'h22,       32'hA5A5A5A5, 2'b00, 1'b0, 32'h0,        2'b00);
        vt[3]  = mk(5'd7,  5'd7,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h22,       32'h22,       2'b00, 1'b0, 32'h22,       2'b00);
        vt[4]  = mk(5'd0,  5'd0,  1'b1,5'd0,  32'h12345678, 1'b0,5'd0,  32'h0,        1'b1,5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        vt[5]  = mk(5'd0,  5'd0,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        vt[6]  = mk(5'd9,  5'd3,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b1,5'd9,  1'b0, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b0, 32'h0,        2'b00);
        vt[7]  = mk(5'd9,  5'd9,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h0,        32'h0,        2'b11, 1'b1, 32'h0,        2'b11);
        vt[8]  = mk(5'd9,  5'd3,  1'b0,5'd0,  32'h0,        1'b1,5'd9,  32'h99,       1'b0,5'd0,  1'b0, 32'h99,       32'hA5A5A5A5, 2'b00, 1'b1, 32'h0,        2'b01);
        vt[9]  = mk(5'd9,  5'd9,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h99,       32'h99,       2'b00, 1'b0, 32'h99,       2'b00);
        vt[10] = mk(5'd9,  5'd9,  1'b0,5'd0,  32'h0,        1'b1,5'd9,  32'h77,       1'b1,5'd9,  1'b0, 32'h77,       32'h77,       2'b00, 1'b0, 32'h99,       2'b00);
        vt[11] = mk(5'd9,  5'd3,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h77,       32'hA5A5A5A5, 2'b01, 1'b1, 32'h77,       2'b01);
        vt[12] = mk(5'd4,  5'd9,  1'b0,5'd0,  32'h0,        1'b1,5'd9,  32'h55,       1'b1,5'd4,  1'b0, 32'h0,        32'h55,       2'b00, 1'b1, 32'h0,        2'b10);
        vt[13] = mk(5'd4,  5'd6,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b1,5'd6,  1'b0, 32'h0,        32'h0,        2'b01, 1'b1, 32'h0,        2'b01);
        vt[14] = mk(5'd4,  5'd6,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b1, 32'h0,        32'h0,        2'b11, 1'b1, 32'h0,        2'b11);
        vt[15] = mk(5'd4,  5'd6,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        vt[16] = mk(5'd4,  5'd8,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b1,5'd4,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        vt[17] = mk(5'd4,  5'd8,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b1,5'd8,  1'b1, 32'h0,        32'h0,        2'b01, 1'b1, 32'h0,        2'b01);
        vt[18] = mk(5'd4,  5'd8,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h0,        32'h0,        2'b10, 1'b1, 32'h0,        2'b10);
        vt[19] = mk(5'd8,  5'd8,  1'b1,5'd8,  32'h88,       1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h88,       32'h88,       2'b11, 1'b1, 32'h0,        2'b11);
        vt[20] = mk(5'd8,  5'd2,  1'b0,5'd0,  32'h0,        1'b1,5'd8,  32'h123,      1'b0,5'd0,  1'b0, 32'h123,      32'h0,        2'b00, 1'b1, 32'h88,       2'b01);
        vt[21] = mk(5'd8,  5'd8,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h123,      32'h123,      2'b00, 1'b0, 32'h123,      2'b00);
        vt[22] = mk(5'd1,  5'd2,  1'b1,5'd1,  32'h1111,     1'b1,5'd2,  32'h2222,     1'b0,5'd0,  1'b0, 32'h1111,     32'h2222,     2'b00, 1'b0, 32'h0,        2'b00);
        vt[23] = mk(5'd1,  5'd2,  1'b0,5'd0,  32'h0,        1'b0,5'd0,  32'h0,        1'b0,5'd0,  1'b0, 32'h1111,     32'h2222,     2'b00, 1'b0, 32'h1111,     2'b00);

        // Power-on reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_busy", {62'h0, rd_busy}, 64'h0);
        chk("reset_any_busy", {63'h0, any_busy}, 64'h0);
        chk("reset_nb_rd_data", nb_rd_data, 64'h0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rd_addr  = {vt[i].ra1, vt[i].ra0};
            w0_en    = vt[i].w0e; w0_addr = vt[i].w0a; w0_data = vt[i].w0d;
            w1_en    = vt[i].w1e; w1_addr = vt[i].w1a; w1_data = vt[i].w1d;
            iss_en   = vt[i].ie;  iss_addr = vt[i].ia;
            sb_flush = vt[i].fl;
            #1;
            chk($sformatf("v%0d_rd0", i), {32'h0, rd_data[31:0]}, {32'h0, vt[i].d0});
            chk($sformatf("v%0d_rd1", i), {32'h0, rd_data[63:32]}, {32'h0, vt[i].d1});
            chk($sformatf("v%0d_busy", i), {62'h0, rd_busy}, {62'h0, vt[i].b});
            chk($sformatf("v%0d_any", i), {63'h0, any_busy}, {63'h0, vt[i].any});
            chk($sformatf("v%0d_nb_rd0", i), {32'h0, nb_rd_data[31:0]}, {32'h0, vt[i].nd0});
            chk($sformatf("v%0d_nb_busy", i), {62'h0, nb_rd_busy}, {62'h0, vt[i].nb});
        end

        // Mid-run asynchronous reset: write x5, mark x10 busy, then reset between edges.
        @(negedge clk);
        idle_inputs();
        w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd10;
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd10, 5'd5};
        #1;
        chk("pre_rst_x5", {32'h0, rd_data[31:0]}, {32'h0, 32'hDEADBEEF});
        chk("pre_rst_x10_busy", {62'h0, rd_busy}, {62'h0, 2'b10});
        chk("pre_rst_any", {63'h0, any_busy}, {63'h0, 1'b1});
        // Keep a write and an issue in flight while reset is asserted.
        w1_en = 1'b1; w1_addr = 5'd12; w1_data = 32'hCAFE;
        iss_en = 1'b1; iss_addr = 5'd11;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_x5", {32'h0, rd_data[31:0]}, 64'h0);
        chk("async_rst_nb_x5", {32'h0, nb_rd_data[31:0]}, 64'h0);
        chk("async_rst_busy", {62'h0, rd_busy}, 64'h0);
        chk("async_rst_any", {63'h0, any_busy}, 64'h0);
        chk("async_rst_nb_any", {63'h0, nb_any_busy}, 64'h0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        rd_addr = {5'd11, 5'd12};
        #1;
        chk("post_rst_x12", {32'h0, nb_rd_data[31:0]}, 64'h0);
        chk("post_rst_any", {63'h0, any_busy}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
